regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 162 ++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter.
// Shares one register-file write port between the pipeline writeback and a
// small in-order queue of multi-cycle-unit results. Writeback normally wins.
// A starvation counter forces the queue head through after STARVE_LIMIT
// blocked cycles. A writeback to a register that has older queued results
// kills those entries (write-after-write), so a stale result never overwrites
// a newer one.
//
// grant  | meaning
// FORCE  | queue starved: head drains, a real writeback is stalled
// WB     | pipeline writeback wins the port
// QUEUE  | port idle otherwise, head drains
// NONE   | nothing to write
module regfile_wb_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        wb_stall,
  input  logic        mdu_valid,
  output logic        mdu_ready,
  input  logic [4:0]  mdu_addr,
  input  logic [31:0] mdu_data,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic        pend1,
  output logic        pend2
);

  localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(DEPTH);
  localparam logic [3:0]    STARVE_C = 4'(STARVE_LIMIT);

  logic          q_valid [DEPTH];
  logic [4:0]    q_addr  [DEPTH];
  logic [31:0]   q_data  [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [3:0]    starve_cnt;

  logic          q_nonempty;
  logic          wb_req;
  logic          push_en;
  logic          pop;
  logic          wb_grant;
  logic          head_valid;
  logic [4:0]    head_addr;
  logic [31:0]   head_data;

  // Address 0 is the hardwired zero register: such requests are accepted but never written.
  assign q_nonempty = (count != '0);
  assign wb_req     = wb_valid && (wb_addr != 5'd0);
  assign mdu_ready  = reset && (count < DEPTH_C);
  assign push_en    = mdu_valid && mdu_ready && (mdu_addr != 5'd0);
  assign head_valid = q_valid[rd_ptr];
  assign head_addr  = q_addr[rd_ptr];
  assign head_data  = q_data[rd_ptr];

  // Per-cycle grant resolution and write-port drive; a killed head still pops but does not write.
  always_comb begin
    wb_grant = 1'b0;
    pop      = 1'b0;
    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = 32'd0;
    wb_stall = 1'b0;
    if (reset) begin
      if (q_nonempty && (starve_cnt == STARVE_C)) begin
        pop      = 1'b1;
        wb_stall = wb_req;
        if (head_valid) begin
          rf_we    = 1'b1;
          rf_waddr = head_addr;
          rf_wdata = head_data;
        end
      end else if (wb_req) begin
        wb_grant = 1'b1;
        rf_we    = 1'b1;
        rf_waddr = wb_addr;
        rf_wdata = wb_data;
      end else if (q_nonempty) begin
        pop = 1'b1;
        if (head_valid) begin
          rf_we    = 1'b1;
          rf_waddr = head_addr;
          rf_wdata = head_data;
        end
      end
    end
  end

  // Pending-write lookup for decode; an entry becomes visible the cycle after it is pushed.
  always_comb begin
    pend1 = 1'b0;
    pend2 = 1'b0;
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (q_valid[i] && (raddr1 != 5'd0) && (q_addr[i] == raddr1)) pend1 = 1'b1;
        if (q_valid[i] && (raddr2 != 5'd0) && (q_addr[i] == raddr2)) pend2 = 1'b1;
      end
    end
  end

  // Entry payload storage; contents are don't-care while the valid bit is clear.
  always_ff @(posedge clk) begin
    if (push_en) begin
      q_addr[wr_ptr] <= mdu_addr;
      q_data[wr_ptr] <= mdu_data;
    end
  end

  // Entry valid bits: WAW kill, clear on pop, set on push.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) q_valid[i] <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wb_grant && q_valid[i] && (q_addr[i] == wb_addr)) q_valid[i] <= 1'b0;
      end
      if (pop)     q_valid[rd_ptr] <= 1'b0;
      if (push_en) q_valid[wr_ptr] <= 1'b1;
    end
  end

  // Pointers wrap naturally at DEPTH; killed entries still occupy a slot until popped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Starvation counter: counts writeback wins over a waiting queue, saturating at the limit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      starve_cnt <= 4'd0;
    end else if (pop || !q_nonempty) begin
      starve_cnt <= 4'd0;
    end else if (wb_grant && (starve_cnt != STARVE_C)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: per-cycle vector table through a scoreboard
// queue, then a starvation sequence and a check of the shadow register file.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        wb_stall;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_addr;
  logic [31:0] mdu_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic        pend1;
  logic        pend2;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] shadow [32] = '{default: 32'd0};

  regfile_wb_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_stall(wb_stall),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_addr(mdu_addr), .mdu_data(mdu_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .raddr1(raddr1), .raddr2(raddr2), .pend1(pend1), .pend2(pend2)
  );

  always #5 clk = ~clk;

  // Shadow register file built from the write port.
  always @(posedge clk) begin
    if (rf_we) shadow[rf_waddr] <= rf_wdata;
  end

  typedef struct {
    logic        rst;
    logic        wv;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        mv;
    logic [4:0]  ma;
    logic [31:0] md;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        stall;
    logic        ready;
    logic        p1;
    logic        p2;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  function automatic vec_t v(input logic rst, input logic wv, input logic [4:0] wa,
                             input logic [31:0] wd, input logic mv, input logic [4:0] ma,
                             input logic [31:0] md, input logic [4:0] r1, input logic [4:0] r2,
                             input logic we, input logic [4:0] waddr, input logic [31:0] wdata,
                             input logic stall, input logic ready, input logic p1, input logic p2);
    vec_t t;
    t.rst = rst; t.wv = wv; t.wa = wa; t.wd = wd; t.mv = mv; t.ma = ma; t.md = md;
    t.r1 = r1; t.r2 = r2; t.we = we; t.waddr = waddr; t.wdata = wdata;
    t.stall = stall; t.ready = ready; t.p1 = p1; t.p2 = p2;
    return t;
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", name, row, act, exp);
    end
  endtask

  task automatic idle_inputs();
    wb_valid = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
    mdu_valid = 1'b0; mdu_addr = 5'd0; mdu_data = 32'd0;
    raddr1 = 5'd0; raddr2 = 5'd0;
  endtask

  initial begin
    vec_t d;
    vec_t e;
    bit   seen;
    int   n_wb;
    reset = 1'b0;
    idle_inputs();

    //               rst wv wa  wd      mv ma  md      r1  r2 | we waddr wdata   st rdy p1 p2
    // reset holds every output low
    vecs.push_back(v(0, 1, 5,  'h11,   1, 3,  'h33,   3,  0,   0, 0,  'h0,    0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0,  'h0,    0, 0,  'h0,    0,  0,   0, 0,  'h0,    0, 0, 0, 0));
    // idle queue: writeback goes straight through
    vecs.push_back(v(1, 1, 5,  'h11,   0, 0,  'h0,    0,  0,   1, 5,  'h11,   0, 1, 0, 0));
    // fill the queue while the pipeline is busy, then drain in order
    vecs.push_back(v(1, 1, 10, 'hA0,   1, 3,  'h33,   3,  0,   1, 10, 'hA0,   0, 1, 0, 0));
    vecs.push_back(v(1, 1, 11, 'hA1,   1, 4,  'h44,   3,  4,   1, 11, 'hA1,   0, 1, 1, 0));
    vecs.push_back(v(1, 0, 0,  'h0,    1, 8,  'h88,   3,  4,   1, 3,  'h33,   0, 0, 1, 1));
    vecs.push_back(v(1, 0, 0,  'h0,    0, 0,  'h0,    3,  4,   1, 4,  'h44,   0, 1, 0, 1));
    vecs.push_back(v(1, 0, 0,  'h0,    0, 0,  'h0,    3,  4,   0, 0,  'h0,    0, 1, 0, 0));
    // starvation: four writeback wins, then a forced queue write with stall
    vecs.push_back(v(1, 0, 0,  'h0,    1, 7,  'h77,   7,  0,   0, 0,  'h0,    0, 1, 0, 0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(v(1, 1, 9, 'h90,  0, 0,  'h0,    7,  0,   1, 9,  'h90,   0, 1, 1, 0));
    vecs.push_back(v(1, 1, 9,  'h90,   0, 0,  'h0,    7,  0,   1, 7,  'h77,   1, 1, 1, 0));
    vecs.push_back(v(1, 1, 9,  'h90,   0, 0,  'h0,    7,  0,   1, 9,  'h90,   0, 1, 0, 0));
    // WAW kill: newer writeback invalidates the queued result
    vecs.push_back(v(1, 0, 0,  'h0,    1, 6,  'hAA,   6,  0,   0, 0,  'h0,    0, 1, 0, 0));
    vecs.push_back(v(1, 1, 6,  'hBB,   0, 0,  'h0,    6,  0,   1, 6,  'hBB,   0, 1, 1, 0));
    vecs.push_back(v(1, 0, 0,  'h0,    0, 0,  'h0,    6,  0,   0, 0,  'h0,    0, 1, 0, 0));
    vecs.push_back(v(1, 0, 0,  'h0,    0, 0,  'h0,    6,  0,   0, 0,  'h0,    0, 1, 0, 0));
    // address zero from both sources: accepted, never written, nothing queued
    vecs.push_back(v(1, 1, 0,  'h66,   1, 0,  'h55,   0,  0,   0, 0,  'h0,    0, 1, 0, 0));
    vecs.push_back(v(1, 0, 0,  'h0,    0, 0,  'h0,    0,  0,   0, 0,  'h0,    0, 1, 0, 0));
    // reset mid-operation drops two queued entries
    vecs.push_back(v(1, 1, 20, 'hD0,   1, 12, 'hC1,   12, 13,  1, 20, 'hD0,   0, 1, 0, 0));
    vecs.push_back(v(1, 1, 21, 'hD1,   1, 13, 'hC2,   12, 13,  1, 21, 'hD1,   0, 1, 1, 0));
    vecs.push_back(v(0, 0, 0,  'h0,    0, 0,  'h0,    12, 13,  0, 0,  'h0,    0, 0, 0, 0));
    // push accepted on the first edge after reset
    vecs.push_back(v(1, 0, 0,  'h0,    1, 14, 'hE0,   12, 13,  0, 0,  'h0,    0, 1, 0, 0));
    vecs.push_back(v(1, 0, 0,  'h0,    0, 0,  'h0,    14, 0,   1, 14, 'hE0,   0, 1, 1, 0));
    vecs.push_back(v(1, 0, 0,  'h0,    0, 0,  'h0,    14, 0,   0, 0,  'h0,    0, 1, 0, 0));

    foreach (vecs[k]) begin
      @(posedge clk);
      #1;
      d = vecs[k];
      reset = d.rst; wb_valid = d.wv; wb_addr = d.wa; wb_data = d.wd;
      mdu_valid = d.mv; mdu_addr = d.ma; mdu_data = d.md; raddr1 = d.r1; raddr2 = d.r2;
      sb.push_back(d);
      @(negedge clk);
      e = sb.pop_front();
      chk("rf_we",     k, {31'd0, rf_we},     {31'd0, e.we});
      chk("rf_waddr",  k, {27'd0, rf_waddr},  {27'd0, e.waddr});
      chk("rf_wdata",  k, rf_wdata,           e.wdata);
      chk("wb_stall",  k, {31'd0, wb_stall},  {31'd0, e.stall});
      chk("mdu_ready", k, {31'd0, mdu_ready}, {31'd0, e.ready});
      chk("pend1",     k, {31'd0, pend1},     {31'd0, e.p1});
      chk("pend2",     k, {31'd0, pend2},     {31'd0, e.p2});
    end

    // Starvation from a cold start: the push cycle itself is a writeback win,
    // then STARVE_LIMIT more before the queue is forced.
    @(posedge clk);
    #1;
    idle_inputs();
    wb_valid = 1'b1; wb_addr = 5'd16; wb_data = 32'h16;
    mdu_valid = 1'b1; mdu_addr = 5'd15; mdu_data = 32'hF5; raddr1 = 5'd15;
    seen = 1'b0;
    n_wb = 0;
    for (int c = 0; c < 12 && !seen; c++) begin
      @(negedge clk);
      if (rf_we && rf_waddr == 5'd15) begin
        seen = 1'b1;
        chk("force_stall", c, {31'd0, wb_stall}, 32'd1);
        chk("force_data",  c, rf_wdata, 32'hF5);
      end else if (rf_we && rf_waddr == 5'd16) begin
        n_wb++;
      end
      @(posedge clk);
      #1;
      mdu_valid = 1'b0;
    end
    chk("force_seen", 0, {31'd0, seen}, 32'd1);
    chk("wb_wins_before_force", 0, n_wb, 32'd5);
    @(negedge clk);
    chk("after_force_waddr", 0, {27'd0, rf_waddr}, 32'd16);
    chk("after_force_stall", 0, {31'd0, wb_stall}, 32'd0);
    @(posedge clk);
    #1;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);

    chk("reg3",  0, shadow[3],  32'h33);
    chk("reg4",  0, shadow[4],  32'h44);
    chk("reg6",  0, shadow[6],  32'hBB);
    chk("reg7",  0, shadow[7],  32'h77);
    chk("reg12", 0, shadow[12], 32'h0);
    chk("reg13", 0, shadow[13], 32'h0);
    chk("reg14", 0, shadow[14], 32'hE0);
    chk("reg15", 0, shadow[15], 32'hF5);
    chk("reg8",  0, shadow[8],  32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
